ram_port_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer in front of the single-port RAM (en / wr_rd / addr / data_in / data_out / out_en). It serialises write and read commands from two independent masters onto the RAM's one port. It tracks a single outstanding read and routes the returned data to the requester that issued it. A read that gets no response is closed by a timeout. The block sits between the masters and the RAM instance, and is the only driver of the RAM port.

---
 rtl/ram_arb_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 28 ++
 rtl/ram_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and constants for the two-master RAM port arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TIMEOUT    = 8;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-way round-robin pick based on last-served id.
// Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_winner,
  output logic o_any_req
);

  always_comb begin
    o_any_req = i_req0 | i_req1;
    o_winner  = M0;
    if (i_req0 && i_req1) begin
      o_winner = ~i_last;
    end else if (i_req1) begin
      o_winner = M1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Round-robin sequencer sharing one single-port RAM between two
//               masters, with single outstanding read and read timeout.
// Revision    : 1.0  initial release
// ============================================================================
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr_rd0,
  input  logic                  wr_rd1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic                  rerr0,
  output logic                  rerr1,
  output logic                  ram_en,
  output logic                  ram_wr_rd,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_out_en
);

  localparam int              CW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   C_CNT_LAST = CW'(TIMEOUT - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_owner;
  logic                    r_last;
  logic [CW-1:0]           r_cnt;
  logic                    w_winner;
  logic                    w_any_req;
  logic                    w_issue;
  logic                    w_done;
  logic                    w_err;
  logic                    w_win_wr;
  logic [ADDR_WIDTH-1:0]   w_win_addr;
  logic [DATA_WIDTH-1:0]   w_win_data;
  logic [DATA_WIDTH-1:0]   w_rdata;

  rr_arb2 u_rr_arb2 (
    .i_req0    (req0),
    .i_req1    (req1),
    .i_last    (r_last),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  assign w_win_wr   = (w_winner == M1) ? wr_rd1 : wr_rd0;
  assign w_win_addr = (w_winner == M1) ? addr1  : addr0;
  assign w_win_data = (w_winner == M1) ? wdata1 : wdata0;
  assign w_rdata    = w_err ? '0 : ram_data_out;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_issue     = 1'b1;
          w_state_nxt = w_win_wr ? WRITE : READ_WAIT;
        end
      end
      WRITE: w_state_nxt = IDLE;
      READ_WAIT: begin
        // Returned data takes priority over a timeout landing on the same cycle.
        if (ram_out_en) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == C_CNT_LAST) begin
          w_done      = 1'b1;
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_owner     <= M0;
      r_last      <= M1;
      r_cnt       <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      ram_en      <= 1'b0;
      ram_wr_rd   <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rerr0       <= 1'b0;
      rerr1       <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      gnt0    <= w_issue && (w_winner == M0);
      gnt1    <= w_issue && (w_winner == M1);
      ram_en  <= w_issue;
      rvalid0 <= w_done && (r_owner == M0);
      rvalid1 <= w_done && (r_owner == M1);
      rerr0   <= w_err && (r_owner == M0);
      rerr1   <= w_err && (r_owner == M1);
      if (w_issue) begin
        ram_wr_rd   <= w_win_wr;
        ram_addr    <= w_win_addr;
        ram_data_in <= w_win_data;
        r_owner     <= w_winner;
        r_last      <= w_winner;
        r_cnt       <= '0;
      end else if (r_state == READ_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done && (r_owner == M0)) rdata0 <= w_rdata;
      if (w_done && (r_owner == M1)) rdata1 <= w_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Directed bench for ram_port_arbiter with a 1-cycle RAM model
//               and a read-completion scoreboard queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ram_port_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TO = 8;

  typedef struct packed {
    logic          m;
    logic [DW-1:0] d;
    logic          e;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req0, req1, wr_rd0, wr_rd1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_en, ram_wr_rd;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic          m_out_en;
  logic          ram_out_en;
  logic          mute;
  logic          force_oe;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .req1(req1), .wr_rd0(wr_rd0), .wr_rd1(wr_rd1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rerr0(rerr0), .rerr1(rerr1),
    .ram_en(ram_en), .ram_wr_rd(ram_wr_rd), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .ram_out_en(ram_out_en)
  );

  // Single-port RAM with one cycle read latency; mute drops read responses.
  always @(posedge clk) begin
    m_out_en <= 1'b0;
    if (ram_en) begin
      if (ram_wr_rd) begin
        mem[ram_addr] <= ram_data_in;
      end else if (!mute) begin
        m_out_en     <= 1'b1;
        ram_data_out <= mem[ram_addr];
      end
    end
  end
  assign ram_out_en = m_out_en | force_oe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic m, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int wcyc);
    logic got;
    got  = 1'b0;
    wcyc = 0;
    if (m) begin req1 = 1'b1; wr_rd1 = wr; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; wr_rd0 = wr; addr0 = a; wdata0 = d; end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if ((m ? gnt1 : gnt0) === 1'b1) begin
        got  = 1'b1;
        wcyc = i;
        break;
      end
    end
    if (m) req1 = 1'b0; else req0 = 1'b0;
    chk("gnt_seen", {31'd0, got}, 32'd1);
    if (got) begin
      chk("gnt_other", {31'd0, m ? gnt0 : gnt1}, 32'd0);
      chk("ram_en", {31'd0, ram_en}, 32'd1);
      chk("ram_wr_rd", {31'd0, ram_wr_rd}, {31'd0, wr});
      chk("ram_addr", {28'd0, ram_addr}, {28'd0, a});
      if (wr) chk("ram_data_in", {24'd0, ram_data_in}, {24'd0, d});
    end
  endtask

  task automatic wait_rvalid(output int cyc);
    logic got;
    exp_t e;
    got = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
        got = 1'b1;
        cyc = i;
        break;
      end
    end
    e = sbq.pop_front();
    chk("rvalid_seen", {31'd0, got}, 32'd1);
    if (got) begin
      chk("rvalid_sel", {30'd0, rvalid1, rvalid0}, e.m ? 32'd2 : 32'd1);
      chk("rdata", {24'd0, e.m ? rdata1 : rdata0}, {24'd0, e.d});
      chk("rerr", {30'd0, rerr1, rerr0}, e.e ? (e.m ? 32'd2 : 32'd1) : 32'd0);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w, lat;
    logic exp_m, gm, early, got1, rv_seen;
    logic [DW-1:0] d0, d1;

    rstn = 1'b0; req0 = 0; req1 = 0; wr_rd0 = 0; wr_rd1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mute = 1'b0; force_oe = 1'b0;
    repeat (2) tick();
    chk("rst_ctrl", {24'd0, gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, ram_en, ram_wr_rd}, 32'd0);
    chk("rst_data", {rdata0, rdata1, ram_data_in, 4'd0, ram_addr}, 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_ram_en", {29'd0, ram_en, gnt0, gnt1}, 32'd0);
    end

    // Single write by master 0 then read back by master 1.
    issue(1'b0, 1'b1, 4'd5, 8'hA5, w);
    tick();
    sbq.push_back('{m: 1'b1, d: 8'hA5, e: 1'b0});
    issue(1'b1, 1'b0, 4'd5, 8'h00, w);
    wait_rvalid(lat);
    chk("read_latency", lat, 32'd2);
    tick();
    chk("rdata_hold", {23'd0, rvalid1, rdata1}, {24'd0, 8'hA5});

    // Tie from reset: grants alternate starting with master 0.
    do_reset();
    d0 = 8'h10; d1 = 8'h20;
    req0 = 1; wr_rd0 = 1; addr0 = 4'd1; wdata0 = d0;
    req1 = 1; wr_rd1 = 1; addr1 = 4'd2; wdata1 = d1;
    exp_m = 1'b0;
    for (int g = 0; g < 4; g++) begin
      got1 = 1'b0; gm = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (gnt0 === 1'b1 || gnt1 === 1'b1) begin got1 = 1'b1; gm = gnt1; break; end
      end
      chk("tie_gnt_seen", {31'd0, got1}, 32'd1);
      chk("tie_order", {31'd0, gm}, {31'd0, exp_m});
      chk("tie_data", {24'd0, ram_data_in}, {24'd0, exp_m ? d1 : d0});
      if (g == 3) begin req0 = 0; req1 = 0; end
      else if (gm) begin d1 = d1 + 8'd1; wdata1 = d1; end
      else begin d0 = d0 + 8'd1; wdata0 = d0; end
      exp_m = ~exp_m;
    end
    tick();
    tick();
    chk("tie_quiet", {30'd0, gnt0, gnt1}, 32'd0);

    // Read under contention: master 1 waits until master 0's read completes.
    issue(1'b1, 1'b1, 4'd3, 8'h3C, w);
    tick();
    sbq.push_back('{m: 1'b0, d: 8'h3C, e: 1'b0});
    req0 = 1; wr_rd0 = 0; addr0 = 4'd3;
    req1 = 1; wr_rd1 = 1; addr1 = 4'd7; wdata1 = 8'h77;
    early = 1'b0; rv_seen = 1'b0; got1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt0 === 1'b1) req0 = 0;
      if (gnt1 === 1'b1) begin
        if (!rv_seen) early = 1'b1;
        got1 = 1'b1;
        req1 = 0;
        break;
      end
      if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
        rv_seen = 1'b1;
        chk("cont_rvalid0", {30'd0, rvalid1, rvalid0}, 32'd1);
        chk("cont_rdata0", {24'd0, rdata0}, 32'h3C);
        void'(sbq.pop_front());
      end
    end
    req0 = 0; req1 = 0;
    chk("cont_no_early_gnt1", {31'd0, early}, 32'd0);
    chk("cont_gnt1_after", {30'd0, rv_seen, got1}, 32'd3);
    tick();

    // Timeout: no RAM response.
    mute = 1'b1;
    sbq.push_back('{m: 1'b1, d: 8'h00, e: 1'b1});
    issue(1'b1, 1'b0, 4'd9, 8'h00, w);
    wait_rvalid(lat);
    chk("timeout_latency", lat, TO);
    mute = 1'b0;
    issue(1'b0, 1'b1, 4'd4, 8'h44, w);
    chk("idle_after_timeout", w, 32'd1);
    tick();

    // Reset in the middle of a read: response is dropped, pointer restored.
    issue(1'b1, 1'b0, 4'd3, 8'h00, w);
    rstn = 1'b0;
    #2;
    chk("midrst_outputs", {29'd0, ram_en, gnt0, gnt1}, 32'd0);
    tick();
    rstn = 1'b1;
    force_oe = 1'b1;
    tick();
    force_oe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
      tick();
    end
    req0 = 1; wr_rd0 = 1; addr0 = 4'd6; wdata0 = 8'h66;
    req1 = 1; wr_rd1 = 1; addr1 = 4'd8; wdata1 = 8'h88;
    got1 = 1'b0; gm = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin got1 = 1'b1; gm = gnt1; break; end
    end
    req0 = 0; req1 = 0;
    chk("midrst_tie_first", {30'd0, got1, gm}, 32'd2);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
